mem_arbiter: RTL and testbench

Single-port frame-buffer arbiter in the 125 MHz processing domain, between the Gaussian/preprocess pipeline output and the back-side CDC FIFO toward the display. It shares one BRAM port between the pipeline writer and a display-refill reader. Writes have priority, with an optional starvation guard for reads. Each read pass streams one full frame into the FIFO, triggered by the display request.

---
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Frame-buffer BRAM port arbiter: writes win, reads stream one frame per display request.
// Optional starvation guard for reads enabled by defining MEM_ARB_STARVE_EN.
module mem_arbiter #(
    parameter int DATA_WIDTH   = 12,
    parameter int BRAM_DEPTH   = 307200,
    parameter int ADDR_W       = $clog2(BRAM_DEPTH),
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_flush,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_req,
    input  logic                  i_almostfull,
    output logic                  o_wr,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic                  o_bram_en,
    output logic                  o_bram_we,
    output logic [ADDR_W-1:0]     o_bram_addr,
    output logic [DATA_WIDTH-1:0] o_bram_wdata,
    input  logic [DATA_WIDTH-1:0] i_bram_rdata,
    output logic                  o_busy,
    output logic                  o_frame_done,
    output logic                  o_overflow
);

    if (STARVE_LIMIT < 2) begin : g_bad_limit
        $error("STARVE_LIMIT must be at least 2");
    end

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

    state_t                state, state_nxt;
    logic [ADDR_W-1:0]     waddr, raddr;
    logic [DATA_WIDTH-1:0] hold_p0 [2];
    logic [1:0]            hold_cnt;
    logic                  req_p1, req_p2;
    logic                  rd_pend, forced;
    logic                  gnt_hold, gnt_in, gnt_rd, gnt_wr;
    logic                  hold_pop, hold_push, hold_drop;

    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
        return (a == ADDR_W'(BRAM_DEPTH - 1)) ? '0 : a + ADDR_W'(1);
    endfunction

    assign rd_pend   = (state == S_READ) && !i_almostfull;
    assign gnt_hold  = !i_flush && !forced && (hold_cnt != 2'd0);
    assign gnt_in    = !i_flush && !forced && (hold_cnt == 2'd0) && i_valid;
    assign gnt_rd    = !i_flush && rd_pend && (forced || (!gnt_hold && !gnt_in));
    assign gnt_wr    = gnt_hold || gnt_in;
    assign hold_pop  = gnt_hold;
    // A full hold buffer can still accept a pixel in a cycle where its head drains.
    assign hold_push = i_valid && !i_flush && !gnt_in && ((hold_cnt != 2'd2) || hold_pop);
    assign hold_drop = i_valid && !i_flush && !gnt_in && (hold_cnt == 2'd2) && !hold_pop;

`ifdef MEM_ARB_STARVE_EN
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    logic [STARVE_W-1:0] starve_cnt;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)
            starve_cnt <= '0;
        else if (i_flush || (state != S_READ) || gnt_rd)
            starve_cnt <= '0;
        else if (rd_pend)
            starve_cnt <= starve_cnt + STARVE_W'(1);
    end

    assign forced = rd_pend && (starve_cnt == STARVE_W'(STARVE_LIMIT));
`else
    assign forced = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        if (i_flush) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (req_p1 && !req_p2) state_nxt = S_READ;
                S_READ:  if (gnt_rd && (raddr == ADDR_W'(BRAM_DEPTH - 1))) state_nxt = S_DRAIN;
                S_DRAIN: state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Stage p0 -> p1: grant decision registered onto the BRAM port
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state        <= S_IDLE;
            req_p1       <= 1'b0;
            req_p2       <= 1'b0;
            waddr        <= '0;
            raddr        <= '0;
            hold_cnt     <= 2'd0;
            o_bram_en    <= 1'b0;
            o_bram_we    <= 1'b0;
            o_bram_addr  <= '0;
            o_bram_wdata <= '0;
            o_wr         <= 1'b0;
            o_frame_done <= 1'b0;
            o_overflow   <= 1'b0;
        end else begin
            state     <= state_nxt;
            req_p1    <= i_req;
            req_p2    <= req_p1;
            o_bram_en <= gnt_wr || gnt_rd;
            o_bram_we <= gnt_wr;
            if (gnt_wr) begin
                o_bram_addr  <= waddr;
                o_bram_wdata <= gnt_hold ? hold_p0[0] : i_data;
            end else if (gnt_rd) begin
                o_bram_addr <= raddr;
            end
            // Stage p1 -> p2: BRAM read latency, flush kills the in-flight read
            o_wr         <= o_bram_en && !o_bram_we && !i_flush;
            o_frame_done <= (state == S_DRAIN) && !i_flush;
            if (hold_drop)
                o_overflow <= 1'b1;
            if (i_flush) begin
                waddr    <= '0;
                raddr    <= '0;
                hold_cnt <= 2'd0;
            end else begin
                if (gnt_wr)
                    waddr <= wrap_inc(waddr);
                if (gnt_rd)
                    raddr <= wrap_inc(raddr);
                if (hold_push && !hold_pop)
                    hold_cnt <= hold_cnt + 2'd1;
                else if (hold_pop && !hold_push)
                    hold_cnt <= hold_cnt - 2'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (hold_push) begin
            if (hold_pop) begin
                if (hold_cnt == 2'd2) begin
                    hold_p0[0] <= hold_p0[1];
                    hold_p0[1] <= i_data;
                end else begin
                    hold_p0[0] <= i_data;
                end
            end else begin
                hold_p0[hold_cnt[0]] <= i_data;
            end
        end else if (hold_pop) begin
            hold_p0[0] <= hold_p0[1];
        end
    end

    assign o_busy  = (state != S_IDLE);
    assign o_wdata = o_wr ? i_bram_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter against a cycle-level reference model
// (small frame of 64 pixels so full passes stay short).
module tb_mem_arbiter;
    localparam int DW = 12;
    localparam int D  = 64;
    localparam int AW = 6;
    localparam int L  = 8;
`ifdef MEM_ARB_STARVE_EN
    localparam bit STARVE = 1'b1;
`else
    localparam bit STARVE = 1'b0;
`endif

    logic clk = 1'b0, rstn = 1'b1, flush = 1'b0, valid = 1'b0, req = 1'b0, af = 1'b0;
    logic [DW-1:0] data = '0, rdata = '0;
    logic wr, bram_en, bram_we, busy, done, ovf;
    logic [DW-1:0] wdata, bram_wdata;
    logic [AW-1:0] bram_addr;

    always #5 clk = ~clk;

    mem_arbiter #(.DATA_WIDTH(DW), .BRAM_DEPTH(D), .STARVE_LIMIT(L)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_flush(flush), .i_valid(valid), .i_data(data),
        .i_req(req), .i_almostfull(af), .o_wr(wr), .o_wdata(wdata),
        .o_bram_en(bram_en), .o_bram_we(bram_we), .o_bram_addr(bram_addr),
        .o_bram_wdata(bram_wdata), .i_bram_rdata(rdata), .o_busy(busy),
        .o_frame_done(done), .o_overflow(ovf));

    // BRAM environment: one port, one-cycle read latency
    logic [DW-1:0] mem [D];
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we) mem[bram_addr] <= bram_wdata;
            else         rdata <= mem[bram_addr];
        end
    end

    function automatic logic [DW-1:0] pat(input int i);
        return DW'((i * 37 + 5) & 'hfff);
    endfunction

    int n_vec = 0, n_err = 0, cycnt = 0;
    bit chk_on = 1'b0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cycnt);
        end
    endtask

    // ---------------- reference model ----------------
    int ph, wa, ra, sc;              // ph: 0 idle, 1 reading, 2 draining
    bit rq1, rq2, m_ovf;
    logic [DW-1:0] hq[$];
    logic [DW-1:0] mimg [D];
    bit e_en, e_we, e_wr, e_busy, e_done, e_ovf;
    int e_addr;
    logic [DW-1:0] e_wdata, e_rd;

    task automatic model_reset();
        ph = 0; wa = 0; ra = 0; sc = 0; rq1 = 0; rq2 = 0; m_ovf = 0; hq.delete();
        e_en = 0; e_we = 0; e_wr = 0; e_busy = 0; e_done = 0; e_ovf = 0;
        e_addr = 0; e_wdata = '0; e_rd = '0;
    endtask

    // Consumes this cycle's inputs, produces the outputs expected next cycle.
    task automatic model_step();
        bit pend, forced, g_hold, g_in, g_rd, last;
        bit n_wr;
        logic [DW-1:0] n_rd;
        n_wr = e_en && !e_we && !flush;
        n_rd = mimg[e_addr];
        if (e_en && e_we) mimg[e_addr] = e_wdata;
        pend   = (ph == 1) && !af;
        forced = STARVE && pend && (sc == L);
        g_hold = 0; g_in = 0; g_rd = 0;
        if (!flush) begin
            if (forced)              g_rd = 1;
            else if (hq.size() > 0)  g_hold = 1;
            else if (valid)          g_in = 1;
            else if (pend)           g_rd = 1;
        end
        e_wr = n_wr; e_rd = n_rd;
        e_en = g_hold || g_in || g_rd;
        e_we = g_hold || g_in;
        last = g_rd && (ra == D - 1);
        if (g_hold)    begin e_addr = wa; e_wdata = hq.pop_front(); end
        else if (g_in) begin e_addr = wa; e_wdata = data; end
        else if (g_rd) e_addr = ra;
        if (g_hold || g_in) wa = (wa + 1) % D;
        if (g_rd) ra = (ra + 1) % D;
        if (valid && !flush && !g_in) begin
            if (hq.size() < 2) hq.push_back(data);
            else m_ovf = 1;
        end
        e_done = (ph == 2) && !flush;
        if (flush || ph != 1 || g_rd) sc = 0;
        else if (pend) sc++;
        if (flush) begin
            ph = 0; wa = 0; ra = 0; hq.delete();
        end else begin
            case (ph)
                0: if (rq1 && !rq2) ph = 1;
                1: if (last) ph = 2;
                default: ph = 0;
            endcase
        end
        rq2 = rq1; rq1 = req;
        e_busy = (ph != 0);
        e_ovf = m_ovf;
    endtask

    // ---------------- compare process and observation logs ----------------
    int wlog_a[$], rd_a[$], rd_cyc[$], wr_cyc[$], done_cyc[$];
    logic [DW-1:0] wlog_d[$], rdat[$];

    always @(posedge clk) begin
        cycnt++;
        #1;
        if (chk_on) begin
            cmp("bram_en", bram_en, e_en);
            cmp("bram_we", bram_we, e_we);
            if (e_en) cmp("bram_addr", bram_addr, e_addr);
            if (e_en && e_we) cmp("bram_wdata", bram_wdata, e_wdata);
            cmp("fifo_wr", wr, e_wr);
            if (e_wr) cmp("fifo_wdata", wdata, e_rd);
            cmp("busy", busy, e_busy);
            cmp("frame_done", done, e_done);
            cmp("overflow", ovf, e_ovf);
        end
        if (bram_en && bram_we) begin wlog_a.push_back(int'(bram_addr)); wlog_d.push_back(bram_wdata); end
        if (bram_en && !bram_we) begin rd_a.push_back(int'(bram_addr)); rd_cyc.push_back(cycnt); end
        if (wr) begin rdat.push_back(wdata); wr_cyc.push_back(cycnt); end
        if (done) done_cyc.push_back(cycnt);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(); @(posedge clk); #3; endtask

    task automatic apply(input bit v, input logic [DW-1:0] d, input bit rq, input bit a, input bit fl);
        valid = v; data = d; req = rq; af = a; flush = fl;
        model_step();
    endtask

    task automatic drive(input bit v, input logic [DW-1:0] d, input bit rq, input bit a, input bit fl);
        tick(); apply(v, d, rq, a, fl);
    endtask

    task automatic clr_logs();
        wlog_a.delete(); wlog_d.delete(); rd_a.delete(); rd_cyc.delete();
        rdat.delete(); wr_cyc.delete(); done_cyc.delete();
    endtask

    task automatic check_zero(input string tag);
        cmp({tag, "_wr"}, wr, 0);          cmp({tag, "_wdata"}, wdata, 0);
        cmp({tag, "_en"}, bram_en, 0);     cmp({tag, "_we"}, bram_we, 0);
        cmp({tag, "_addr"}, bram_addr, 0); cmp({tag, "_bwdata"}, bram_wdata, 0);
        cmp({tag, "_busy"}, busy, 0);      cmp({tag, "_done"}, done, 0);
        cmp({tag, "_ovf"}, ovf, 0);
    endtask

    task automatic do_reset();
        tick();
        rstn = 0; valid = 0; req = 0; af = 0; flush = 0; data = '0;
        model_reset();
        #1 check_zero("rst");
        tick();
        rstn = 1;
        model_step();
    endtask

    task automatic count_in(input int q[$], input int lo, input int hi, output int n);
        n = 0;
        foreach (q[i]) if (q[i] >= lo && q[i] <= hi) n++;
    endtask

    task automatic wait_done(input int bound, input bit v);
        for (int k = 0; k < bound; k++) begin
            if (done_cyc.size() > 0) break;
            drive(v, '0, 1, 0, 0);
        end
    endtask

    initial begin
        int e, s, n, bad;
        bit got;
        logic [DW-1:0] d;
        for (int i = 0; i < D; i++) begin mem[i] = pat(i); mimg[i] = pat(i); end
        model_reset();

        // A: reset state
        do_reset();
        chk_on = 1;

        // B: full pass, no writes, no almost-full
        clr_logs();
        drive(0, '0, 1, 0, 0);
        e = cycnt;
        wait_done(D + 20, 0);
        drive(0, '0, 1, 0, 0);
        cmp("pass_done_count", done_cyc.size(), 1);
        if (done_cyc.size() > 0) cmp("pass_done_latency", done_cyc[0] - e, D + 3);
        cmp("pass_wr_count", rdat.size(), D);
        bad = 0;
        foreach (rdat[i]) if (rdat[i] !== pat(i) || rd_a[i] != i) bad++;
        cmp("pass_order_errors", bad, 0);
        drive(0, '0, 0, 0, 0);

        // C: almost-full stall mid pass
        clr_logs();
        for (int k = 0; k < 100 && rd_a.size() < 20; k++) drive(0, '0, 1, 0, 0);
        cmp("stall_reached", rd_a.size() >= 20, 1);
        drive(0, '0, 1, 1, 0);
        s = cycnt;
        for (int k = 1; k < 20; k++) drive(0, '0, 1, 1, 0);
        wait_done(D + 40, 0);
        drive(0, '0, 0, 0, 0);
        count_in(rd_cyc, s + 1, s + 20, n);
        cmp("stall_reads_issued", n, 0);
        count_in(wr_cyc, s + 1, s + 20, n);
        n_vec++;
        if (n > 2) begin n_err++; $display("FAIL stall_trailing_wr: got %0d, want at most 2", n); end
        cmp("stall_wr_count", rdat.size(), D);
        bad = 0;
        foreach (rdat[i]) if (rdat[i] !== pat(i) || rd_a[i] != i) bad++;
        cmp("stall_order_errors", bad, 0);

        // D: idle write stream lands at addresses 0..4
        do_reset();
        clr_logs();
        for (int k = 1; k <= 5; k++) drive(1, DW'(k), 0, 0, 0);
        drive(0, '0, 0, 0, 0);
        drive(0, '0, 0, 0, 0);
        cmp("wstream_count", wlog_a.size(), 5);
        for (int k = 0; k < 5 && k < wlog_a.size(); k++) begin
            cmp("wstream_addr", wlog_a[k], k);
            cmp("wstream_data", wlog_d[k], k + 1);
        end

        // E: write address wrap
        do_reset();
        clr_logs();
        for (int k = 0; k <= D; k++) drive(1, DW'(100 + k), 0, 0, 0);
        drive(0, '0, 0, 0, 0);
        drive(0, '0, 0, 0, 0);
        cmp("wrap_count", wlog_a.size(), D + 1);
        if (wlog_a.size() == D + 1) begin
            cmp("wrap_last_addr", wlog_a[D], 0);
            cmp("wrap_prev_addr", wlog_a[D - 1], D - 1);
        end

        // F: continuous writes during a read pass
        do_reset();
        clr_logs();
        drive(1, DW'(1), 1, 0, 0);
        e = cycnt;
        for (int k = 2; k <= 26; k++) drive(1, DW'(k), 1, 0, 0);
        wait_done(D + 60, 0);
        drive(0, '0, 0, 0, 0);
        count_in(rd_cyc, e + 3, e + 26, n);
        cmp("contend_reads", n, STARVE ? 2 : 0);
        cmp("contend_ovf", ovf, 0);
        cmp("contend_wcount", wlog_d.size(), 26);
        bad = 0;
        foreach (wlog_d[i]) if (wlog_d[i] !== DW'(i + 1) || wlog_a[i] != i) bad++;
        cmp("contend_worder_errors", bad, 0);
        cmp("contend_done", done_cyc.size(), 1);

        // G: flush with a read in flight
        do_reset();
        clr_logs();
        got = 0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (bram_en && !bram_we && bram_addr == AW'(20)) begin
                got = 1;
                apply(0, '0, 1, 0, 1);
                break;
            end
            apply(0, '0, 1, 0, 0);
        end
        cmp("flush_reached", got, 1);
        clr_logs();
        tick();
        cmp("flush_no_wr", wr, 0);
        cmp("flush_busy", busy, 0);
        apply(1, 12'habc, 1, 0, 0);
        for (int k = 0; k < 5; k++) drive(0, '0, 1, 0, 0);
        cmp("flush_no_done", done_cyc.size(), 0);
        cmp("flush_waddr0", wlog_a.size() == 1 ? wlog_a[0] : -1, 0);
        drive(0, '0, 0, 0, 0);
        clr_logs();
        for (int k = 0; k < 4; k++) drive(0, '0, 1, 0, 0);
        cmp("flush_raddr0", rd_a.size() > 0 ? rd_a[0] : -1, 0);

        // H: asynchronous reset mid pass
        got = 0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (bram_en && !bram_we && bram_addr == AW'(30)) begin got = 1; break; end
            apply(0, '0, 1, 0, 0);
        end
        cmp("midrst_reached", got, 1);
        rstn = 0; valid = 0; req = 0; af = 0; flush = 0;
        model_reset();
        #1 check_zero("midrst");
        tick();
        rstn = 1;
        apply(0, '0, 0, 0, 0);
        clr_logs();
        for (int k = 0; k < 5; k++) drive(0, '0, 1, 0, 0);
        cmp("midrst_raddr0", rd_a.size() > 0 ? rd_a[0] : -1, 0);

        // I: randomised traffic
        do_reset();
        req = 0;
        for (int k = 0; k < 3000; k++) begin
            d = DW'($urandom);
            drive($urandom_range(0, 1) == 1, d,
                  ($urandom_range(0, 49) == 0) ? !req : req,
                  $urandom_range(0, 4) == 0,
                  $urandom_range(0, 99) == 0);
        end
        drive(0, '0, 0, 0, 0);
        drive(0, '0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
